// File: rtl/riscv_core_pkg.sv
// Shared types and widths for the RISC-V core execute-stage units.
`default_nettype none

package riscv_core_pkg;

  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_e;

endpackage

`default_nettype wire

// File: rtl/riscv_core_muldiv_iter.sv
// Radix-2 engine: {hi,lo} shift register with one shift-add (mul) or
// restoring shift-subtract (div) step per cycle.
`default_nettype none

module riscv_core_muldiv_iter
  import riscv_core_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode_div,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] load_m,
  input  logic [XLEN-1:0] load_lo,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] m;
  logic [XLEN:0]   add_sum;
  logic [XLEN-1:0] shifted;
  logic            no_borrow;

  assign add_sum   = {1'b0, hi} + {1'b0, m};
  assign shifted   = {hi[XLEN-2:0], lo[XLEN-1]};
  // Partial remainder is always below m, so the true difference fits XLEN bits.
  assign no_borrow = {hi, lo[XLEN-1]} >= {1'b0, m};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m  <= '0;
      hi <= '0;
      lo <= '0;
    end else if (load) begin
      m  <= load_m;
      hi <= '0;
      lo <= load_lo;
    end else if (step) begin
      if (!mode_div) begin
        if (lo[0]) {hi, lo} <= {add_sum, lo[XLEN-1:1]};
        else       {hi, lo} <= {1'b0, hi, lo[XLEN-1:1]};
      end else begin
        hi <= no_borrow ? (shifted - m) : shifted;
        lo <= {lo[XLEN-2:0], no_borrow};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/riscv_core_muldiv_unit.sv
// Iterative M-extension multiply/divide sequencer with valid/ready in and out,
// flush abort, and RV64 W-form support.
`default_nettype none

module riscv_core_muldiv_unit
  import riscv_core_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_muldiv_valid,
  output logic            o_muldiv_ready,
  input  logic [2:0]      i_muldiv_op,
  input  logic            i_muldiv_word,
  input  logic [XLEN-1:0] i_muldiv_rs1,
  input  logic [XLEN-1:0] i_muldiv_rs2,
  input  logic            i_muldiv_flush,
  output logic            o_muldiv_valid,
  input  logic            i_muldiv_out_ready,
  output logic [XLEN-1:0] o_muldiv_result,
  output logic            o_muldiv_busy
);

  localparam int CW = $clog2(XLEN);

  muldiv_state_e   state, state_nx;
  muldiv_op_e      op;
  logic            word;
  logic [XLEN-1:0] opa, opb;
  logic            neg;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] result;

  logic            accept, is_div, is_rem, signed_a, signed_b, sa, sb;
  logic            div_zero, ovf, special;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg, special_res;
  logic [XLEN-1:0] eng_hi, eng_lo, q_s, r_s, sel, fix_res;
  logic [2*XLEN-1:0] prod_s;
  logic            eng_load, eng_step;

  assign accept   = i_muldiv_valid && (state == ST_IDLE) && !i_muldiv_flush;
  assign is_div   = op[2];
  assign is_rem   = op inside {OP_REM, OP_REMU};
  assign signed_a = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign signed_b = op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};

  assign a_ext = word ? {{(XLEN-32){signed_a & opa[31]}}, opa[31:0]} : opa;
  assign b_ext = word ? {{(XLEN-32){signed_b & opb[31]}}, opb[31:0]} : opb;
  assign sa    = signed_a & a_ext[XLEN-1];
  assign sb    = signed_b & b_ext[XLEN-1];
  assign a_mag = sa ? -a_ext : a_ext;
  assign b_mag = sb ? -b_ext : b_ext;

  assign min_neg  = word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = is_div && (b_ext == '0);
  assign ovf      = is_div && signed_b && (a_ext == min_neg) && (b_ext == '1);
  assign special  = div_zero || ovf;
  assign special_res = div_zero ? (is_rem ? a_ext : '1)
                                : (is_rem ? '0 : a_ext);

  assign eng_load = (state == ST_PREP) && !i_muldiv_flush && !special;
  assign eng_step = (state == ST_CALC) && !i_muldiv_flush;

  // W-form divides pre-shift the dividend so 32 steps leave the quotient in lo[31:0].
  riscv_core_muldiv_iter u_iter (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .mode_div (is_div),
    .load     (eng_load),
    .step     (eng_step),
    .load_m   (is_div ? b_mag : a_mag),
    .load_lo  (is_div ? (word ? (a_mag << 32) : a_mag) : b_mag),
    .hi       (eng_hi),
    .lo       (eng_lo)
  );

  assign prod_s = neg ? -{eng_hi, eng_lo} : {eng_hi, eng_lo};
  assign q_s    = neg ? -eng_lo : eng_lo;
  assign r_s    = neg ? -eng_hi : eng_hi;

  // A 32-step multiply leaves the product shifted up by XLEN-32 bits.
  always_comb begin
    sel = '0;
    case (op)
      OP_MUL:                        sel = word ? {{(XLEN-32){1'b0}}, prod_s[XLEN-1:XLEN-32]}
                                                : prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  sel = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               sel = q_s;
      default:                       sel = r_s;
    endcase
    fix_res = word ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (i_muldiv_valid)     state_nx = ST_PREP;
      ST_PREP:                          state_nx = special ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt == '0)           state_nx = ST_FIX;
      ST_FIX:                           state_nx = ST_DONE;
      ST_DONE: if (i_muldiv_out_ready) state_nx = ST_IDLE;
      default:                          state_nx = ST_IDLE;
    endcase
    if (i_muldiv_flush) state_nx = ST_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_IDLE;
      op     <= OP_MUL;
      word   <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op   <= muldiv_op_e'(i_muldiv_op);
        word <= i_muldiv_word;
        opa  <= i_muldiv_rs1;
        opb  <= i_muldiv_rs2;
      end
      if (state == ST_PREP && !i_muldiv_flush) begin
        neg <= is_rem ? sa : (sa ^ sb);
        cnt <= word ? CW'(31) : CW'(XLEN-1);
        if (special) result <= special_res;
      end
      if (eng_step && cnt != '0) cnt <= cnt - 1'b1;
      if (state == ST_FIX && !i_muldiv_flush) result <= fix_res;
    end
  end

  assign o_muldiv_ready  = (state == ST_IDLE);
  assign o_muldiv_valid  = (state == ST_DONE);
  assign o_muldiv_busy   = (state != ST_IDLE);
  assign o_muldiv_result = result;

endmodule

`default_nettype wire
